ahb_sram_slave: RTL and testbench

- AHB-lite slave wrapping a word-organised on-chip data SRAM; sits directly downstream of the load/store AHB master on the data bus.
- Decodes address/control phases and applies byte-lane writes from HSIZE/HADDR.
- Returns read data after a programmable number of wait states.
- Flags out-of-range and misaligned accesses with the two-cycle AHB ERROR response.

---
 rtl/ahb_sram_slave.sv | 267 ++++++++++++++++++++++++++
 tb/tb_ahb_sram_slave.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave.sv
// -----------------------------------------------------------------------------
// ahb_sram_slave
//
// AHB-lite slave in front of a word-organised on-chip data SRAM on the
// load/store data bus. The address phase is decoded and checked when it is
// accepted. Valid transfers get WAIT_STATES low-HREADYOUT cycles and then one
// final data-phase cycle. In that final cycle a read returns the full SRAM
// word, and a write updates the byte lanes selected by HSIZE/HADDR at the
// closing edge. Misaligned or out-of-range transfers get the two-cycle ERROR
// response and never touch the SRAM.
//
// Ports:
//   clk              system clock
//   rst_n            synchronous active-low reset (SRAM contents are kept)
//   slv_hsel_i       slave select
//   slv_htrans_i     transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   slv_haddr_i      byte address
//   slv_hwrite_i     1 = write, 0 = read
//   slv_hsize_i      0 = byte, 1 = half, 2 = word, others are illegal
//   slv_hburst_i     burst type, unused: every beat is a single transfer
//   slv_hwdata_i     write data, sampled in the final data-phase cycle
//   slv_hready_i     bus HREADY; gates the address-phase accept
//   slv_hreadyout_o  slave ready (registered)
//   slv_hresp_o      0 = OKAY, 1 = ERROR (registered)
//   slv_hrdata_o     read data, zero outside a read's final cycle (registered)
// -----------------------------------------------------------------------------
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  slv_hsel_i,
    input  logic [1:0]            slv_htrans_i,
    input  logic [ADDR_WIDTH-1:0] slv_haddr_i,
    input  logic                  slv_hwrite_i,
    input  logic [2:0]            slv_hsize_i,
    input  logic [2:0]            slv_hburst_i,
    input  logic [DATA_WIDTH-1:0] slv_hwdata_i,
    input  logic                  slv_hready_i,
    output logic                  slv_hreadyout_o,
    output logic                  slv_hresp_o,
    output logic [DATA_WIDTH-1:0] slv_hrdata_o
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // The counter is loaded with N-1 on entry to WAIT and leaves at zero,
    // which gives exactly N low-HREADYOUT cycles.
    localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
    localparam logic       HAS_WAIT  = (WAIT_STATES > 0) ? 1'b1 : 1'b0;

    // The SRAM depth is widened to the address width so the range check
    // compares the whole word index. Upper address bits are not dropped.
    localparam logic [ADDR_WIDTH-1:0] DEPTH_W = ADDR_WIDTH'(MEM_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_LAST = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------

    // Byte-lane strobes for a transfer of the given size at the given offset.
    function automatic logic [NUM_LANES-1:0] byte_strobe(input logic [2:0] size,
                                                         input logic [1:0] offset);
        logic [NUM_LANES-1:0] strb;
        case (size)
            3'd0:    strb = 4'b0001 << offset;
            3'd1:    strb = offset[1] ? 4'b1100 : 4'b0011;
            3'd2:    strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

    // Replace the strobed lanes of old_word with the same lanes of new_word.
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(input logic [DATA_WIDTH-1:0] old_word,
                                                          input logic [DATA_WIDTH-1:0] new_word,
                                                          input logic [NUM_LANES-1:0]  strb);
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < NUM_LANES; i++) begin
            res[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

    // An illegal size, a misaligned half/word, or a word index past the SRAM.
    function automatic logic xfer_error(input logic [2:0]            size,
                                        input logic [ADDR_WIDTH-1:0] addr);
        logic err;
        case (size)
            3'd0:    err = 1'b0;
            3'd1:    err = addr[0];
            3'd2:    err = (addr[1:0] != 2'b00);
            default: err = 1'b1;
        endcase
        if ({2'b00, addr[ADDR_WIDTH-1:2]} >= DEPTH_W) begin
            err = 1'b1;
        end
        return err;
    endfunction

    // -------------------------------------------------------------------------
    // Storage and state
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

    state_t                state_r;
    logic [2:0]            cnt_r;
    logic [IDX_W-1:0]      idx_r;
    logic [NUM_LANES-1:0]  strb_r;
    logic                  hwrite_r;
    logic                  hreadyout_r;
    logic                  hresp_r;
    logic [DATA_WIDTH-1:0] hrdata_r;

    state_t                state_nx_s;
    logic [2:0]            cnt_nx_s;
    logic                  accept_s;
    logic                  err_s;
    logic                  capture_s;
    logic                  commit_s;
    logic [IDX_W-1:0]      req_idx_s;
    logic [IDX_W-1:0]      rd_idx_s;
    logic                  rd_write_s;
    logic [DATA_WIDTH-1:0] rd_raw_s;
    logic [DATA_WIDTH-1:0] rd_word_s;
    logic                  hreadyout_nx_s;
    logic                  hresp_nx_s;
    logic [DATA_WIDTH-1:0] hrdata_nx_s;

    // The burst type does not affect any beat.
    logic unused_burst_s;
    assign unused_burst_s = ^slv_hburst_i;

    assign accept_s  = slv_hsel_i & slv_htrans_i[1] & slv_hready_i;
    assign err_s     = xfer_error(slv_hsize_i, slv_haddr_i);
    assign req_idx_s = slv_haddr_i[IDX_W+1:2];

    // A write commits at the edge that closes its final data-phase cycle.
    // Reset at that edge aborts the write.
    assign commit_s = (state_r == ST_LAST) & hwrite_r & rst_n;

    // Next-state logic for the data-phase sequencer.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        capture_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_LAST, ST_ERR2: begin
                if (accept_s) begin
                    capture_s = 1'b1;
                    if (err_s) begin
                        state_nx_s = ST_ERR1;
                    end else if (HAS_WAIT) begin
                        state_nx_s = ST_WAIT;
                        cnt_nx_s   = WAIT_LOAD;
                    end else begin
                        state_nx_s = ST_LAST;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 3'd0) begin
                    state_nx_s = ST_LAST;
                end else begin
                    cnt_nx_s = cnt_r - 3'd1;
                end
            end
            ST_ERR1: begin
                state_nx_s = ST_ERR2;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Read word for the cycle about to start. The output is registered, so a
    // read whose final cycle follows a committing write to the same word has
    // to see the merged value that the SRAM holds after that edge.
    always_comb begin
        rd_idx_s   = capture_s ? req_idx_s : idx_r;
        rd_write_s = capture_s ? slv_hwrite_i : hwrite_r;
        rd_raw_s   = mem_r[rd_idx_s];
        rd_word_s  = (commit_s && (idx_r == rd_idx_s))
                     ? merge_lanes(rd_raw_s, slv_hwdata_i, strb_r)
                     : rd_raw_s;
    end

    // Response outputs decoded from the next state, then registered.
    always_comb begin
        hreadyout_nx_s = 1'b1;
        hresp_nx_s     = 1'b0;
        hrdata_nx_s    = '0;
        case (state_nx_s)
            ST_IDLE: begin
                hreadyout_nx_s = 1'b1;
            end
            ST_WAIT: begin
                hreadyout_nx_s = 1'b0;
            end
            ST_LAST: begin
                hrdata_nx_s = rd_write_s ? '0 : rd_word_s;
            end
            ST_ERR1: begin
                hreadyout_nx_s = 1'b0;
                hresp_nx_s     = 1'b1;
            end
            ST_ERR2: begin
                hresp_nx_s = 1'b1;
            end
            default: begin
                hreadyout_nx_s = 1'b1;
            end
        endcase
    end

    // State, wait counter, captured address phase and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 3'd0;
            idx_r       <= '0;
            strb_r      <= '0;
            hwrite_r    <= 1'b0;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
            hrdata_r    <= '0;
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            hreadyout_r <= hreadyout_nx_s;
            hresp_r     <= hresp_nx_s;
            hrdata_r    <= hrdata_nx_s;
            if (capture_s) begin
                idx_r    <= req_idx_s;
                strb_r   <= byte_strobe(slv_hsize_i, slv_haddr_i[1:0]);
                hwrite_r <= slv_hwrite_i;
            end
        end
    end

    // SRAM byte-lane write port. Contents are not reset.
    always_ff @(posedge clk) begin
        if (commit_s) begin
            mem_r[idx_r] <= merge_lanes(mem_r[idx_r], slv_hwdata_i, strb_r);
        end
    end

    assign slv_hreadyout_o = hreadyout_r;
    assign slv_hresp_o     = hresp_r;
    assign slv_hrdata_o    = hrdata_r;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_ahb_sram_slave
//
// Self-checking bench for ahb_sram_slave. Two instances are used: one with
// zero wait states and one with three. A pipelined AHB master drives queued
// transfers. A transaction-level model predicts each transfer's response
// beats from its type, size and address, and a shadow word array predicts
// the read data.
// -----------------------------------------------------------------------------
module tb_ahb_sram_slave;

    localparam int DEPTH = 1024;

    typedef struct packed {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } tx_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel      [2];
    logic [1:0]  htrans    [2];
    logic [31:0] haddr     [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [2:0]  hburst    [2];
    logic [31:0] hwdata    [2];
    logic        hreadyout [2];
    logic        hresp     [2];
    logic [31:0] hrdata    [2];

    int          n_cmp = 0;
    int          n_err = 0;
    int          ws_of [2] = '{0, 3};
    logic [31:0] ref_mem [2][DEPTH];
    tx_t         q [$];

    always #5 clk = ~clk;

    ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst_n(rst_n),
        .slv_hsel_i(hsel[0]), .slv_htrans_i(htrans[0]), .slv_haddr_i(haddr[0]),
        .slv_hwrite_i(hwrite[0]), .slv_hsize_i(hsize[0]), .slv_hburst_i(hburst[0]),
        .slv_hwdata_i(hwdata[0]), .slv_hready_i(hreadyout[0]),
        .slv_hreadyout_o(hreadyout[0]), .slv_hresp_o(hresp[0]), .slv_hrdata_o(hrdata[0])
    );

    ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst_n(rst_n),
        .slv_hsel_i(hsel[1]), .slv_htrans_i(htrans[1]), .slv_haddr_i(haddr[1]),
        .slv_hwrite_i(hwrite[1]), .slv_hsize_i(hsize[1]), .slv_hburst_i(hburst[1]),
        .slv_hwdata_i(hwdata[1]), .slv_hready_i(hreadyout[1]),
        .slv_hreadyout_o(hreadyout[1]), .slv_hresp_o(hresp[1]), .slv_hrdata_o(hrdata[1])
    );

    // Single comparison point: count it and report a mismatch.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic tx_t mk(input logic sel, input logic [1:0] trans, input logic wr,
                               input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        tx_t t;
        t.sel = sel; t.trans = trans; t.wr = wr; t.size = size; t.addr = addr; t.wdata = wdata;
        return t;
    endfunction

    task automatic wr_tx(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        q.push_back(mk(1'b1, 2'b10, 1'b1, size, addr, wdata));
    endtask

    task automatic rd_tx(input logic [31:0] addr);
        q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, addr, 32'h0));
    endtask

    // Model: the transfer is selected and its type is NONSEQ or SEQ.
    function automatic bit tx_accepted(input tx_t t);
        return t.sel && (t.trans == 2'b10 || t.trans == 2'b11);
    endfunction

    // Model: illegal size, misalignment, or a word beyond the SRAM.
    function automatic bit tx_is_err(input tx_t t);
        if (t.size > 3'd2) return 1'b1;
        if (t.size == 3'd1 && (t.addr % 2) != 0) return 1'b1;
        if (t.size == 3'd2 && (t.addr % 4) != 0) return 1'b1;
        return (t.addr / 4) >= DEPTH;
    endfunction

    // Model: apply a completed valid write to the shadow array, lane by lane.
    task automatic commit_model(input int d, input tx_t t);
        int w;
        int off;
        bit hit;
        if (tx_accepted(t) && !tx_is_err(t) && t.wr) begin
            w   = int'(t.addr / 4);
            off = int'(t.addr % 4);
            for (int lane = 0; lane < 4; lane++) begin
                if (t.size == 3'd0)      hit = (lane == off);
                else if (t.size == 3'd1) hit = ((lane / 2) == (off / 2));
                else                     hit = 1'b1;
                if (hit) ref_mem[d][w][lane*8 +: 8] = t.wdata[lane*8 +: 8];
            end
        end
    endtask

    // Model: expected response for data-phase beat 'beat' of transfer t.
    task automatic check_beat(input int d, input tx_t t, input int beat, output bit last);
        bit          acc;
        bit          err;
        int          nb;
        logic [31:0] exp_rd;
        string       tg;
        acc = tx_accepted(t);
        err = acc && tx_is_err(t);
        if (!acc)     nb = 1;
        else if (err) nb = 2;
        else          nb = ws_of[d] + 1;
        last   = (beat == nb - 1);
        exp_rd = (acc && !err && !t.wr && last) ? ref_mem[d][t.addr / 4] : 32'h0;
        tg = $sformatf("dut%0d %s a=%h sz=%0d beat%0d", d, t.wr ? "wr" : "rd", t.addr, t.size, beat);
        check_val({tg, " hreadyout"}, {31'h0, hreadyout[d]}, {31'h0, last});
        check_val({tg, " hresp"},     {31'h0, hresp[d]},     {31'h0, err});
        check_val({tg, " hrdata"},    hrdata[d],             exp_rd);
    endtask

    task automatic drive_ap(input int d, input tx_t t);
        hsel[d]   = t.sel;
        htrans[d] = t.trans;
        haddr[d]  = t.addr;
        hwrite[d] = t.wr;
        hsize[d]  = t.size;
        hburst[d] = 3'($urandom_range(0, 7));
    endtask

    task automatic drive_idle(input int d);
        hsel[d]   = 1'b0;
        htrans[d] = 2'b00;
        haddr[d]  = 32'h0;
        hwrite[d] = 1'b0;
        hsize[d]  = 3'd0;
        hburst[d] = 3'd0;
    endtask

    // Pipelined master: the next address phase overlaps the current data phase.
    task automatic run_seq(input int d);
        tx_t cur;
        tx_t ap;
        bit  have_cur;
        bit  have_ap;
        bit  last;
        int  beat;
        have_cur = 1'b0;
        beat     = 0;
        cur      = '0;
        @(posedge clk); #1;
        if (q.size() > 0) begin
            ap = q.pop_front(); drive_ap(d, ap); have_ap = 1'b1;
        end else begin
            ap = '0; drive_idle(d); have_ap = 1'b0;
        end
        while (have_cur || have_ap) begin
            @(negedge clk);
            if (have_cur) begin
                check_beat(d, cur, beat, last);
            end else begin
                check_val($sformatf("dut%0d idle hreadyout", d), {31'h0, hreadyout[d]}, 32'h1);
                check_val($sformatf("dut%0d idle hresp", d),     {31'h0, hresp[d]},     32'h0);
                check_val($sformatf("dut%0d idle hrdata", d),    hrdata[d],             32'h0);
                last = 1'b1;
            end
            @(posedge clk); #1;
            if (last) begin
                if (have_cur) commit_model(d, cur);
                cur      = ap;
                have_cur = have_ap;
                beat     = 0;
                hwdata[d] = cur.wdata;
                if (q.size() > 0) begin
                    ap = q.pop_front(); drive_ap(d, ap); have_ap = 1'b1;
                end else begin
                    ap = '0; drive_idle(d); have_ap = 1'b0;
                end
            end else begin
                beat++;
            end
        end
    endtask

    // Fill the random-test pool with known full words.
    task automatic init_pool;
        for (int w = 0; w < 16; w++) wr_tx(3'd2, 32'h100 + 32'(4 * w), $urandom);
    endtask

    task automatic random_traffic(input int n);
        for (int k = 0; k < n; k++) begin
            int          r;
            tx_t         t;
            logic [31:0] word;
            r       = $urandom_range(0, 99);
            word    = 32'h100 + 32'(4 * $urandom_range(0, 15));
            t.sel   = 1'b1;
            t.trans = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
            t.wr    = 1'($urandom_range(0, 1));
            t.wdata = $urandom;
            t.size  = 3'd2;
            t.addr  = word;
            if (r < 8) begin
                case (r % 3)
                    0:       t.trans = 2'b00;
                    1:       t.trans = 2'b01;
                    default: t.sel   = 1'b0;
                endcase
            end else if (r < 20) begin
                case (r % 4)
                    0:       t.size = 3'($urandom_range(3, 7));
                    1:       begin t.size = 3'd1; t.addr = word + (($urandom_range(0, 1) == 0) ? 32'd1 : 32'd3); end
                    2:       t.addr = word + 32'($urandom_range(1, 3));
                    default: t.addr = 32'h1000 | ($urandom & 32'hFFFF_FFFC);
                endcase
            end else begin
                t.size = 3'($urandom_range(0, 2));
                if (t.size == 3'd0)      t.addr = word + 32'($urandom_range(0, 3));
                else if (t.size == 3'd1) t.addr = word + 32'(2 * $urandom_range(0, 1));
                else                     t.addr = word;
            end
            q.push_back(t);
        end
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Main stimulus.
    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            drive_idle(d);
            hwdata[d] = 32'h0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_val($sformatf("dut%0d reset hreadyout", d), {31'h0, hreadyout[d]}, 32'h1);
            check_val($sformatf("dut%0d reset hresp", d),     {31'h0, hresp[d]},     32'h0);
            check_val($sformatf("dut%0d reset hrdata", d),    hrdata[d],             32'h0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Zero wait states: back-to-back write/read, lane writes, ignored phases, error.
        wr_tx(3'd2, 32'h10, 32'h1234_5678);
        rd_tx(32'h10);
        wr_tx(3'd2, 32'h20, 32'hFFFF_FFFF);
        wr_tx(3'd0, 32'h21, 32'hAAAA_AAAA);
        wr_tx(3'd1, 32'h22, 32'h5555_5555);
        rd_tx(32'h20);
        q.push_back(mk(1'b1, 2'b00, 1'b1, 3'd2, 32'h10, 32'hBAD0_BAD0));
        q.push_back(mk(1'b0, 2'b10, 1'b1, 3'd2, 32'h10, 32'hBAD1_BAD1));
        rd_tx(32'h10);
        wr_tx(3'd2, 32'h40, 32'h0F0F_0F0F);
        wr_tx(3'd2, 32'h42, 32'hFFFF_FFFF);
        rd_tx(32'h40);
        run_seq(0);

        // Three wait states: read timing, misaligned and out-of-range errors.
        wr_tx(3'd2, 32'h40, 32'hCAFE_F00D);
        rd_tx(32'h40);
        wr_tx(3'd2, 32'h42, 32'hFFFF_FFFF);
        wr_tx(3'd2, 32'h1000, 32'hFFFF_FFFF);
        rd_tx(32'h40);
        rd_tx(32'h1000);
        wr_tx(3'd2, 32'h80, 32'h0BAD_F00D);
        q.push_back(mk(1'b1, 2'b01, 1'b1, 3'd2, 32'h80, 32'h1111_1111));
        run_seq(1);

        // Reset during the second wait cycle of a write: the write is aborted.
        @(posedge clk); #1;
        drive_ap(1, mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h80, 32'h7777_7777));
        @(posedge clk); #1;
        drive_idle(1);
        hwdata[1] = 32'h7777_7777;
        @(negedge clk);
        check_val("rst-test wait1 hreadyout", {31'h0, hreadyout[1]}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_val("rst-test after hreadyout", {31'h0, hreadyout[1]}, 32'h1);
        check_val("rst-test after hresp",     {31'h0, hresp[1]},     32'h0);
        check_val("rst-test after hrdata",    hrdata[1],             32'h0);
        rst_n = 1'b1;
        rd_tx(32'h80);
        run_seq(1);

        // Randomized traffic on both wait-state configurations.
        for (int d = 0; d < 2; d++) begin
            init_pool();
            random_traffic(80);
            run_seq(d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
